// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port integer register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int          DEF_SP_IDX    = 2;
    localparam logic [31:0] DEF_SP_INIT   = 32'h0000_2ffc;
    localparam int          DEF_ECALL_IDX = 17;

    // Address width for a register count (ceil(log2(n)), minimum 1).
    function automatic int rf_aw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, loading SP_INIT at SP_IDX
// and zero elsewhere, then raises ready and stays in RUN until reset.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int              XLEN    = 32,
    parameter int              NREGS   = 32,
    parameter int              SP_IDX  = DEF_SP_IDX,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(DEF_SP_INIT),
    localparam int             AW      = rf_aw(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            clr_we,
    output logic [AW-1:0]   clr_idx,
    output logic [XLEN-1:0] clr_val,
    output logic            ready
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reset) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (state_q == CLEAR) begin
            // cnt wraps back to 0 on the final write and sits idle in RUN
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(NREGS - 1))
                state_d = RUN;
        end
    end

    assign clr_we  = (state_q == CLEAR) && !reset;
    assign clr_idx = cnt_q;
    assign clr_val = (cnt_q == AW'(SP_IDX)) ? SP_INIT : '0;
    assign ready   = (state_q == RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async reads, two sync writes (port 1 wins
// collisions), hardwired x0, ecall tap, sequenced clear. Same-cycle write->read
// forwarding is enabled with `define REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              NREGS     = 32,
    parameter int              NRD       = 2,
    parameter int              SP_IDX    = DEF_SP_IDX,
    parameter logic [XLEN-1:0] SP_INIT   = XLEN'(DEF_SP_INIT),
    parameter int              ECALL_IDX = DEF_ECALL_IDX,
    localparam int             AW        = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    output logic [XLEN-1:0]     ecall_dout,
    output logic                ready
);

    logic            clr_we;
    logic [AW-1:0]   clr_idx;
    logic [XLEN-1:0] clr_val;

    regfile_clear_fsm #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .SP_IDX (SP_IDX),
        .SP_INIT(SP_INIT)
    ) u_clear (
        .clk    (clk),
        .reset  (reset),
        .clr_we (clr_we),
        .clr_idx(clr_idx),
        .clr_val(clr_val),
        .ready  (ready)
    );

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_en0, wr_en1;

    // Functional writes only in RUN, never under reset, never to x0.
    assign wr_en0 = we0 && ready && !reset && (waddr0 != '0);
    assign wr_en1 = we1 && ready && !reset && (waddr1 != '0);

    always_ff @(posedge clk) begin
        mem[0] <= '0;
        for (int i = 1; i < NREGS; i++) begin
            if (clr_we && clr_idx == AW'(i))
                mem[i] <= clr_val;
            else if (wr_en1 && waddr1 == AW'(i))
                mem[i] <= wdata1;
            else if (wr_en0 && waddr0 == AW'(i))
                mem[i] <= wdata0;
        end
    end

    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    always_comb begin
        rd_data    = '0;
        ecall_dout = '0;
        ra         = '0;
        rv         = '0;
        // Contents are not trustworthy until the clear walk finishes.
        if (ready) begin
            for (int k = 0; k < NRD; k++) begin
                ra = rd_addr[k*AW +: AW];
                rv = (ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
                if (wr_en0 && waddr0 == ra) rv = wdata0;
                if (wr_en1 && waddr1 == ra) rv = wdata1;
`endif
                rd_data[k*XLEN +: XLEN] = rv;
            end
            ecall_dout = (ECALL_IDX == 0) ? '0 : mem[AW'(ECALL_IDX)];
`ifdef REGFILE_BYPASS_EN
            if (wr_en0 && waddr0 == AW'(ECALL_IDX)) ecall_dout = wdata0;
            if (wr_en1 && waddr1 == AW'(ECALL_IDX)) ecall_dout = wdata1;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 32x2 instance plus a 64-entry 4-port one.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;
    localparam int WNREGS = 64;
    localparam int WNRD = 4;
    localparam int WAW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic                we0, we1;
    logic [AW-1:0]       waddr0, waddr1;
    logic [XLEN-1:0]     wdata0, wdata1, ecall_dout;
    logic                ready;

    logic [WNRD*WAW-1:0]  w_rd_addr;
    logic [WNRD*XLEN-1:0] w_rd_data;
    logic                 w_we0, w_we1;
    logic [WAW-1:0]       w_waddr0, w_waddr1;
    logic [XLEN-1:0]      w_wdata0, w_wdata1, w_ecall_dout;
    logic                 w_ready;

    regfile_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .ecall_dout(ecall_dout), .ready(ready)
    );

    regfile_mp #(.NREGS(WNREGS), .NRD(WNRD)) dut64 (
        .clk(clk), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
        .we0(w_we0), .waddr0(w_waddr0), .wdata0(w_wdata0),
        .we1(w_we1), .waddr1(w_waddr1), .wdata1(w_wdata1),
        .ecall_dout(w_ecall_dout), .ready(w_ready)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model[NREGS];

    task automatic push_exp(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        model[2] = 32'h2ffc;
    endtask

    task automatic test_reset();
        exp_t e;
        logic exp_r;
        reset = 1'b1;
        we0 = 0; we1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        w_we0 = 0; w_we1 = 0; w_waddr0 = '0; w_waddr1 = '0; w_wdata0 = '0; w_wdata1 = '0;
        rd_addr = '0; w_rd_addr = '0;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        rd_addr = {5'd5, 5'd2}; #1;
        n_cmp++;
        if (rd_data !== '0) begin n_err++; $display("FAIL reset_rd_zero: got %h want 0", rd_data); end
        reset = 1'b0;
        for (int c = 1; c <= NREGS; c++) begin
            @(posedge clk); #1;
            exp_r = (c == NREGS);
            n_cmp++;
            if (ready !== exp_r) begin
                n_err++; $display("FAIL ready_edge%0d: got %b want %b", c, ready, exp_r);
            end
        end
        @(negedge clk);
        model_clear();
        push_exp("sp_init", 32'h2ffc);
        push_exp("x5_clear", 32'h0);
        push_exp("ecall_clear", 32'h0);
        rd_addr = {5'd5, 5'd2}; #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[63:32] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[63:32], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (ecall_dout !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, ecall_dout, e.val); end
    endtask

    task automatic test_collision();
        exp_t e;
        @(negedge clk);
        rd_addr = {5'd0, 5'd5};
        we0 = 1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        we1 = 1; waddr1 = 5'd5; wdata1 = 32'h1234_5678;
`ifdef REGFILE_BYPASS_EN
        push_exp("collision_same_cycle", 32'h1234_5678);
`else
        push_exp("collision_same_cycle", model[5]);
`endif
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
        @(posedge clk); #1;
        we0 = 0; we1 = 0;
        model[5] = 32'h1234_5678;
        push_exp("collision_port1_wins", model[5]);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
    endtask

    task automatic test_zero_write();
        exp_t e;
        @(negedge clk);
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        rd_addr = {5'd0, 5'd0};
        push_exp("x0_same_cycle", 32'h0);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[63:32] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[63:32], e.val); end
        @(posedge clk); #1;
        we0 = 0; we1 = 0;
        for (int i = 0; i < NREGS; i += 2) begin
            @(negedge clk);
            rd_addr = {5'(i + 1), 5'(i)};
            push_exp($sformatf("entry_x%0d", i), model[i]);
            push_exp($sformatf("entry_x%0d", i + 1), model[i + 1]);
            #1;
            e = exp_q.pop_front(); n_cmp++;
            if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
            e = exp_q.pop_front(); n_cmp++;
            if (rd_data[63:32] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[63:32], e.val); end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        @(negedge clk);
        we0 = 1; waddr0 = 5'd17; wdata0 = 32'h0000_000A;
        rd_addr = {5'd0, 5'd17};
`ifdef REGFILE_BYPASS_EN
        push_exp("x17_same_cycle", 32'hA);
        push_exp("ecall_same_cycle", 32'hA);
`else
        push_exp("x17_same_cycle", model[17]);
        push_exp("ecall_same_cycle", model[17]);
`endif
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (ecall_dout !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, ecall_dout, e.val); end
        @(posedge clk); #1;
        we0 = 0;
        model[17] = 32'hA;
        push_exp("x17_next_cycle", 32'hA);
        push_exp("ecall_next_cycle", 32'hA);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (ecall_dout !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, ecall_dout, e.val); end
    endtask

    task automatic test_clear_restart();
        exp_t e;
        logic exp_r;
        @(negedge clk);
        reset = 1;
        @(posedge clk); @(negedge clk);
        reset = 0;
        for (int c = 1; c < 10; c++) @(posedge clk);
        @(negedge clk);
        reset = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL restart_ready_low: got %b want 0", ready); end
        @(negedge clk);
        reset = 0;
        rd_addr = {5'd0, 5'd3};
        for (int c = 1; c <= NREGS; c++) begin
            // writes aimed at an entry the clear walk has already passed
            we0 = (c >= 20 && c < NREGS); waddr0 = 5'd3; wdata0 = 32'h3333_0000;
            we1 = (c >= 20 && c < NREGS); waddr1 = 5'd3; wdata1 = 32'h3333_1111;
            @(posedge clk); #1;
            exp_r = (c == NREGS);
            n_cmp++;
            if (ready !== exp_r) begin n_err++; $display("FAIL restart_ready_edge%0d: got %b want %b", c, ready, exp_r); end
            @(negedge clk);
        end
        we0 = 0; we1 = 0;
        model_clear();
        push_exp("restart_x3_ignored", model[3]);
        push_exp("restart_sp", model[2]);
        rd_addr = {5'd2, 5'd3}; #1;
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[31:0], e.val); end
        e = exp_q.pop_front(); n_cmp++;
        if (rd_data[63:32] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, rd_data[63:32], e.val); end
    endtask

    task automatic test_wide();
        exp_t e;
        int   c;
        c = 0;
        while (w_ready !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (w_ready !== 1'b1) begin n_err++; $display("FAIL wide_ready_timeout: got %b want 1", w_ready); end
        @(negedge clk);
        w_we0 = 1; w_waddr0 = 6'd1;  w_wdata0 = 32'h1111_1111;
        w_we1 = 1; w_waddr1 = 6'd33; w_wdata1 = 32'h3333_3333;
        @(negedge clk);
        w_waddr0 = 6'd63; w_wdata0 = 32'h6363_6363;
        w_waddr1 = 6'd0;  w_wdata1 = 32'hFFFF_FFFF;
        @(negedge clk);
        w_we0 = 0; w_we1 = 0;
        w_rd_addr = {6'd0, 6'd63, 6'd33, 6'd1};
        push_exp("wide_x1", 32'h1111_1111);
        push_exp("wide_x33", 32'h3333_3333);
        push_exp("wide_x63", 32'h6363_6363);
        push_exp("wide_x0", 32'h0);
        #1;
        for (int k = 0; k < WNRD; k++) begin
            e = exp_q.pop_front(); n_cmp++;
            if (w_rd_data[k*XLEN +: XLEN] !== e.val) begin
                n_err++; $display("FAIL %s: got %h want %h", e.name, w_rd_data[k*XLEN +: XLEN], e.val);
            end
        end
        w_rd_addr = {6'd0, 6'd0, 6'd0, 6'd2};
        push_exp("wide_sp", 32'h2ffc);
        #1;
        e = exp_q.pop_front(); n_cmp++;
        if (w_rd_data[31:0] !== e.val) begin n_err++; $display("FAIL %s: got %h want %h", e.name, w_rd_data[31:0], e.val); end
    endtask

    initial begin
        test_reset();
        test_collision();
        test_zero_write();
        test_bypass();
        test_clear_restart();
        test_wide();
        if (exp_q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
